// File: rtl/cv_ctrl_ports.sv
// Controller-port front end: decodes joystick words onto keypad/joystick pins and
// turns spinner deltas into a rate-limited quadrature phase on p7/p9.
module cv_ctrl_ports #(
    parameter int          NUM_PORTS = 2,
    parameter logic [15:0] SPIN_DIV  = 16'd1337,
    parameter logic [9:0]  SPIN_SAT  = 10'd511
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     clk_en_i,
    input  logic                     swap_i,
    input  logic [32*NUM_PORTS-1:0]  joy_i,
    input  logic [8*NUM_PORTS-1:0]   spin_i,
    input  logic [NUM_PORTS-1:0]     spin_stb_i,
    input  logic [NUM_PORTS-1:0]     ctrl_p5_i,
    input  logic [NUM_PORTS-1:0]     ctrl_p8_i,
    output logic [NUM_PORTS-1:0]     ctrl_p1_o,
    output logic [NUM_PORTS-1:0]     ctrl_p2_o,
    output logic [NUM_PORTS-1:0]     ctrl_p3_o,
    output logic [NUM_PORTS-1:0]     ctrl_p4_o,
    output logic [NUM_PORTS-1:0]     ctrl_p6_o,
    output logic [NUM_PORTS-1:0]     ctrl_p7_o,
    output logic [NUM_PORTS-1:0]     ctrl_p9_o
);

    localparam logic [15:0]        TMR_RELOAD = SPIN_DIV - 16'd1;
    localparam logic signed [12:0] SAT_POS    = {3'b000, SPIN_SAT};
    localparam logic signed [12:0] SAT_NEG    = -SAT_POS;

    function automatic logic signed [10:0] sat11(input logic signed [12:0] v);
        logic signed [12:0] r;
        if (v > SAT_POS)
            r = SAT_POS;
        else if (v < SAT_NEG)
            r = SAT_NEG;
        else
            r = v;
        return r[10:0];
    endfunction

    // Lowest-numbered pressed key wins; order is key0..key9, '*', '#', purple, blue.
    function automatic logic [3:0] key_code(input logic [31:0] j);
        logic [3:0] code;
        if      (j[8])  code = 4'b0011;
        else if (j[9])  code = 4'b1110;
        else if (j[10]) code = 4'b1101;
        else if (j[11]) code = 4'b0110;
        else if (j[12]) code = 4'b0001;
        else if (j[13]) code = 4'b1001;
        else if (j[14]) code = 4'b0111;
        else if (j[15]) code = 4'b1100;
        else if (j[16]) code = 4'b1000;
        else if (j[17]) code = 4'b1011;
        else if (j[6])  code = 4'b1010;
        else if (j[7])  code = 4'b0101;
        else if (j[18]) code = 4'b0100;
        else if (j[19]) code = 4'b0010;
        else            code = 4'b1111;
        return code;
    endfunction

    logic [32*NUM_PORTS-1:0] joy_sw;
    logic [8*NUM_PORTS-1:0]  spin_sw;
    logic [NUM_PORTS-1:0]    stb_sw;

    generate
        if (NUM_PORTS > 1) begin : g_swap
            always_comb begin
                joy_sw  = joy_i;
                spin_sw = spin_i;
                stb_sw  = spin_stb_i;
                if (swap_i) begin
                    joy_sw[63:0]  = {joy_i[31:0], joy_i[63:32]};
                    spin_sw[15:0] = {spin_i[7:0], spin_i[15:8]};
                    stb_sw[1:0]   = {spin_stb_i[0], spin_stb_i[1]};
                end
            end
        end else begin : g_noswap
            logic swap_unused;
            assign swap_unused = swap_i;
            assign joy_sw      = joy_i;
            assign spin_sw     = spin_i;
            assign stb_sw      = spin_stb_i;
        end
    endgenerate

    // Spinner state lives with the output port; only the inputs feeding it are swapped.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [31:0]        joy;
        logic               joy_unused;
        logic signed [7:0]  delta;
        logic               stb;
        logic [4:0]         pins_next;
        logic [4:0]         pins_q;
        logic signed [10:0] acc;
        logic signed [10:0] pend;
        logic [15:0]        tmr;
        logic [1:0]         phase;
        logic               tick;
        logic               step_up;
        logic               step_dn;
        logic signed [12:0] delta_ext;
        logic signed [12:0] delta_now;
        logic signed [12:0] adj;
        logic signed [12:0] acc_sum;
        logic signed [12:0] pend_sum;

        assign joy        = joy_sw[32*p +: 32];
        assign joy_unused = ^joy[31:20];
        assign delta      = spin_sw[8*p +: 8];
        assign stb        = stb_sw[p];

        always_comb begin
            pins_next = 5'b11111;
            if (!ctrl_p5_i[p])
                pins_next = pins_next & {key_code(joy), ~joy[5]};
            if (!ctrl_p8_i[p])
                pins_next = pins_next & {~joy[3], ~joy[2], ~joy[1], ~joy[0], ~joy[4]};
        end

        // Step direction comes from the accumulator before this cycle's delta lands.
        always_comb begin
            tick      = (tmr == 16'd0);
            step_up   = tick && (acc > 11'sd0);
            step_dn   = tick && (acc < 11'sd0);
            delta_ext = {{5{delta[7]}}, delta};
            delta_now = stb ? delta_ext : 13'sd0;
            adj       = step_up ? -13'sd1 : (step_dn ? 13'sd1 : 13'sd0);
            acc_sum   = {{2{acc[10]}}, acc} + {{2{pend[10]}}, pend} + delta_now + adj;
            pend_sum  = {{2{pend[10]}}, pend} + delta_ext;
        end

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                pins_q <= 5'b11111;
                acc    <= '0;
                pend   <= '0;
                tmr    <= TMR_RELOAD;
                phase  <= 2'b00;
            end else if (clk_en_i) begin
                pins_q <= pins_next;
                tmr    <= tick ? TMR_RELOAD : tmr - 16'd1;
                acc    <= sat11(acc_sum);
                pend   <= '0;
                if (step_up)
                    phase <= {phase[0], ~phase[1]};
                else if (step_dn)
                    phase <= {~phase[0], phase[1]};
            end else if (stb) begin
                pend <= sat11(pend_sum);
            end
        end

        assign ctrl_p1_o[p] = pins_q[4];
        assign ctrl_p2_o[p] = pins_q[3];
        assign ctrl_p3_o[p] = pins_q[2];
        assign ctrl_p4_o[p] = pins_q[1];
        assign ctrl_p6_o[p] = pins_q[0];
        assign ctrl_p7_o[p] = ~phase[0];
        assign ctrl_p9_o[p] = ~phase[1];
    end

endmodule
